// File: rtl/mux_rr_fifo_n.sv
// mux_rr_fifo_n: N-channel to 1 multiplexer with a FIFO on each channel.
// A round-robin arbiter feeds a registered valid/ready output stage.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   push_i[N]      per-channel write strobe
//   data_in_i      channel i data on bits [i*W +: W]
//   full_o[N]      channel FIFO holds DEPTH entries
//   empty_o[N]     channel FIFO holds no entries
//   overflow_o[N]  sticky, a push arrived while the channel was full
//   data_out_o     registered output word
//   valid_out_o    data_out_o holds a word
//   ready_in_i     downstream accepts the word when valid_out_o & ready_in_i
//   sel_out_o      channel that sourced data_out_o
//   almost_full_o  free entries <= AF_TH (only when MUX_ALMOST_FULL_EN is defined)
//
// Optional feature macro: MUX_ALMOST_FULL_EN

// One channel FIFO. The count is registered, so full/empty are pure state
// decodes with no combinational path from push.
module mux_rr_fifo_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q;
  logic                    wr, rd;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign overflow_o = ovf_q;
  assign count_o    = cnt_q;
  assign head_o     = mem_q[rd_ptr_q];

  // A push to a full FIFO is dropped even if the same cycle pops it.
  assign wr = push_i & ~full_o;
  assign rd = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (wr && !rd)      cnt_d = cnt_q + CW'(1);
    else if (rd && !wr) cnt_d = cnt_q - CW'(1);
  end

  // Storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      if (push_i && full_o) ovf_q <= 1'b1;
    end
  end
endmodule

module mux_rr_fifo_n #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AF_TH = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N-1:0]         push_i,
  input  logic [N*W-1:0]       data_in_i,
  output logic [N-1:0]         full_o,
  output logic [N-1:0]         empty_o,
  output logic [N-1:0]         overflow_o,
  output logic [W-1:0]         data_out_o,
  output logic                 valid_out_o,
  input  logic                 ready_in_i,
  output logic [$clog2(N)-1:0] sel_out_o
`ifdef MUX_ALMOST_FULL_EN
  ,output logic [N-1:0]        almost_full_o
`endif
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(DEPTH+1);

  logic [N-1:0][W-1:0]  head_w;
  logic [N-1:0][CW-1:0] count_w;
  logic [N-1:0]         pop_w;

  logic [W-1:0]  data_q;
  logic [SW-1:0] sel_q, last_q, gnt;
  logic          valid_q, gnt_vld, load;

  assign load        = ~valid_q | ready_in_i;
  assign data_out_o  = data_q;
  assign sel_out_o   = sel_q;
  assign valid_out_o = valid_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign pop_w[i] = load & gnt_vld & (gnt == SW'(i));

    mux_rr_fifo_lane #(.W(W), .DEPTH(DEPTH)) u_lane (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .push_i     (push_i[i]),
      .data_i     (data_in_i[i*W +: W]),
      .pop_i      (pop_w[i]),
      .head_o     (head_w[i]),
      .count_o    (count_w[i]),
      .full_o     (full_o[i]),
      .empty_o    (empty_o[i]),
      .overflow_o (overflow_o[i])
    );
  end

`ifdef MUX_ALMOST_FULL_EN
  // Free space compared against the threshold; zero at reset while AF_TH < DEPTH.
  for (genvar i = 0; i < N; i++) begin : g_af
    assign almost_full_o[i] = (CW'(DEPTH) - count_w[i]) <= CW'(AF_TH);
  end
`else
  logic unused_count;
  assign unused_count = ^count_w;
`endif

  // Round-robin scan starting just after the last granted channel.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!gnt_vld && !empty_o[idx]) begin
        gnt_vld = 1'b1;
        gnt     = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= SW'(N-1);
    end else if (load) begin
      if (gnt_vld) begin
        data_q  <= head_w[gnt];
        sel_q   <= gnt;
        valid_q <= 1'b1;
        last_q  <= gnt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_fifo_n.sv
module tb_mux_rr_fifo_n;
  localparam int N = 4, W = 8, DEPTH = 4, AF_TH = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  push = '0;
  logic [N*W-1:0] data_in = '0;
  logic          ready = 1'b0;
  logic [N-1:0]  full, empty, overflow;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic [1:0]    sel_out;
`ifdef MUX_ALMOST_FULL_EN
  logic [N-1:0]  almost_full;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_rr_fifo_n #(.N(N), .W(W), .DEPTH(DEPTH), .AF_TH(AF_TH)) dut (
    .clk_i(clk), .reset_i(reset), .push_i(push), .data_in_i(data_in),
    .full_o(full), .empty_o(empty), .overflow_o(overflow),
    .data_out_o(data_out), .valid_out_o(valid_out), .ready_in_i(ready),
    .sel_out_o(sel_out)
`ifdef MUX_ALMOST_FULL_EN
    , .almost_full_o(almost_full)
`endif
  );

  // Reference model: one queue per channel plus the output register contents.
  logic [W-1:0] mq [N][$];
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel, m_last;
  logic [N-1:0] m_ovf;

  function automatic void mdl_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_valid = 0; m_data = '0; m_sel = 0; m_last = N-1; m_ovf = '0;
  endfunction

  function automatic logic [N-1:0] m_empty();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  function automatic logic [N-1:0] m_full();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  function automatic logic [N-1:0] m_af();
    logic [N-1:0] a;
    for (int i = 0; i < N; i++) a[i] = ((DEPTH - mq[i].size()) <= AF_TH);
    return a;
  endfunction

  function automatic void mdl_edge(logic [N-1:0] p, logic [N*W-1:0] d, bit rdy);
    logic [N-1:0] was_full;
    int g;
    was_full = m_full();
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && mq[(m_last + k) % N].size() > 0) g = (m_last + k) % N;
    if (!m_valid || rdy) begin
      if (g >= 0) begin
        m_data = mq[g].pop_front(); m_sel = g; m_valid = 1; m_last = g;
      end else m_valid = 0;
    end
    for (int i = 0; i < N; i++)
      if (p[i]) begin
        if (was_full[i]) m_ovf[i] = 1'b1;
        else mq[i].push_back(d[i*W +: W]);
      end
  endfunction

  // Drive one cycle from a negedge, advance the model at the edge, return at the next negedge.
  task automatic step(input logic [N-1:0] p, input logic [N*W-1:0] d, input bit rdy);
    push = p; data_in = d; ready = rdy;
    @(posedge clk);
    mdl_edge(p, d, rdy);
    @(negedge clk);
    push = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = '0; ready = 1'b0; reset = 1'b1;
    mdl_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; push = '0; mdl_reset();
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (empty !== 4'b1111) begin errors++; $display("FAIL reset_empty: got %b want 1111", empty); end
    checks++; if (full !== 4'b0000) begin errors++; $display("FAIL reset_full: got %b want 0000", full); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b want 0000", overflow); end
    checks++; if (data_out !== 8'h00 || sel_out !== 2'd0) begin errors++; $display("FAIL reset_data_sel: got %h/%0d want 00/0", data_out, sel_out); end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0100, 32'h00A5_0000, 1'b1);
    checks++; if (empty !== 4'b1011 || valid_out !== 1'b0) begin errors++; $display("FAIL single_push: got empty=%b valid=%b want 1011/0", empty, valid_out); end
    step('0, '0, 1'b1);
    checks++; if (valid_out !== 1'b1 || data_out !== 8'hA5 || sel_out !== 2'd2) begin errors++; $display("FAIL single_out: got v=%b d=%h s=%0d want 1/a5/2", valid_out, data_out, sel_out); end
    step('0, '0, 1'b1);
    checks++; if (valid_out !== 1'b0 || empty !== 4'b1111) begin errors++; $display("FAIL single_idle: got v=%b empty=%b want 0/1111", valid_out, empty); end
  endtask

  task automatic test_order();
    logic [7:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++)
      step(4'b1111, {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k), 8'(k)}, 1'b0);
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL order_noovf: got %b want 0000", overflow); end
    for (int i = 0; i < 16; i++) begin
      exp = 8'((i % 4) * 16 + i / 4);
      checks++; if (valid_out !== 1'b1 || data_out !== exp) begin errors++; $display("FAIL order_word%0d: got v=%b d=%h want 1/%h", i, valid_out, data_out, exp); end
      step('0, '0, 1'b1);
    end
    checks++; if (valid_out !== 1'b0 || empty !== 4'b1111) begin errors++; $display("FAIL order_end: got v=%b empty=%b want 0/1111", valid_out, empty); end
  endtask

  task automatic test_stall();
    do_reset();
    step(4'b0001, 32'h0000_003C, 1'b0);
    step('0, '0, 1'b0);
    checks++; if (valid_out !== 1'b1 || data_out !== 8'h3C || sel_out !== 2'd0) begin errors++; $display("FAIL stall_load: got v=%b d=%h s=%0d want 1/3c/0", valid_out, data_out, sel_out); end
    for (int c = 0; c < 3; c++) begin
      step(4'b0110, $urandom, 1'b0);
      checks++; if (valid_out !== 1'b1 || data_out !== 8'h3C || sel_out !== 2'd0) begin errors++; $display("FAIL stall_hold%0d: got v=%b d=%h s=%0d want 1/3c/0", c, valid_out, data_out, sel_out); end
      checks++; if (empty !== m_empty() || full !== m_full()) begin errors++; $display("FAIL stall_fifo%0d: got e=%b f=%b want %b/%b", c, empty, full, m_empty(), m_full()); end
    end
    for (int c = 0; c < 8; c++) begin
      step('0, '0, 1'b1);
      checks++; if (valid_out !== m_valid || data_out !== m_data || sel_out !== 2'(m_sel)) begin errors++; $display("FAIL stall_drain%0d: got v=%b d=%h s=%0d want %b/%h/%0d", c, valid_out, data_out, sel_out, m_valid, m_data, m_sel); end
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    step(4'b0001, 32'h0000_0099, 1'b0);
    step('0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'b0010, {16'h0, 8'(8'h40 + k), 8'h0}, 1'b0);
      if (k == 3) begin
        checks++; if (full !== 4'b0010 || overflow !== 4'b0000) begin errors++; $display("FAIL ovf_full: got f=%b o=%b want 0010/0000", full, overflow); end
      end
    end
    checks++; if (overflow !== 4'b0010 || full !== 4'b0010) begin errors++; $display("FAIL ovf_set: got o=%b f=%b want 0010/0010", overflow, full); end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid_out && sel_out == 2'd1) begin
        checks++; if (data_out !== 8'(8'h40 + n)) begin errors++; $display("FAIL ovf_word%0d: got %h want %h", n, data_out, 8'(8'h40 + n)); end
        n++;
      end
      step('0, '0, 1'b1);
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL ovf_count: got %0d words want 4", n); end
    checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_sticky: got %b want 0010", overflow); end
  endtask

  // Entered with overflow[1] still set from the previous scenario.
  task automatic test_reset_mid();
    step(4'b1001, 32'hC000_00A0, 1'b0);
    step(4'b1001, 32'hC100_00A1, 1'b0);
    step(4'b1000, 32'hC200_0000, 1'b0);
    checks++; if (valid_out !== 1'b1 || empty[0] !== 1'b0 || empty[3] !== 1'b0) begin errors++; $display("FAIL mid_setup: got v=%b e=%b want 1/0xx0", valid_out, empty); end
    @(negedge clk);
    reset = 1'b1; mdl_reset();
    #1;
    checks++; if (valid_out !== 1'b0 || empty !== 4'b1111 || overflow !== 4'b0000) begin errors++; $display("FAIL mid_reset: got v=%b e=%b o=%b want 0/1111/0000", valid_out, empty, overflow); end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    step(4'b1001, 32'hD300_00D0, 1'b1);
    step('0, '0, 1'b1);
    checks++; if (valid_out !== 1'b1 || sel_out !== 2'd0 || data_out !== 8'hD0) begin errors++; $display("FAIL mid_first: got v=%b s=%0d d=%h want 1/0/d0", valid_out, sel_out, data_out); end
    step('0, '0, 1'b1);
  endtask

`ifdef MUX_ALMOST_FULL_EN
  task automatic test_almost_full();
    do_reset();
    step(4'b0010, 32'h0000_1100, 1'b0);
    step('0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 32'(k), 1'b0);
      checks++; if (almost_full[0] !== (k == 2)) begin errors++; $display("FAIL af_rise%0d: got %b want %b", k, almost_full[0], (k == 2)); end
    end
    step('0, '0, 1'b1);
    checks++; if (almost_full[0] !== 1'b0 || sel_out !== 2'd0) begin errors++; $display("FAIL af_fall: got af=%b s=%0d want 0/0", almost_full[0], sel_out); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] p;
    bit rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      p   = ($urandom % 3 == 0) ? '0 : N'($urandom);
      rdy = ($urandom % 4) != 0;
      step(p, $urandom, rdy);
      checks++;
      if ({valid_out, sel_out, data_out, empty, full, overflow} !==
          {m_valid, 2'(m_sel), m_data, m_empty(), m_full(), m_ovf}) begin
        errors++;
        $display("FAIL random_c%0d: got v=%b s=%0d d=%h e=%b f=%b o=%b want v=%b s=%0d d=%h e=%b f=%b o=%b",
                 c, valid_out, sel_out, data_out, empty, full, overflow,
                 m_valid, m_sel, m_data, m_empty(), m_full(), m_ovf);
      end
`ifdef MUX_ALMOST_FULL_EN
      checks++; if (almost_full !== m_af()) begin errors++; $display("FAIL random_af_c%0d: got %b want %b", c, almost_full, m_af()); end
`endif
    end
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_single();
    test_order();
    test_stall();
    test_overflow();
    test_reset_mid();
`ifdef MUX_ALMOST_FULL_EN
    test_almost_full();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
